cnt_mod10_alert: RTL
====================

Name: cnt_mod10_alert

Overview:
- Upstream block sequencer for the FFT datapath. Counts accepted input beats modulo MOD and emits the one-cycle alert_mod10 pulse that arms the downstream 1-bit count/mux-select FSM.
- Also tracks the block index within a frame, flushes the downstream FSM's 4-cycle window after the last block, and signals frame completion.

Parameters:
- MOD, 10, beats per block; legal range MOD >= 4, so back-to-back alerts never overlap the downstream 4-cycle window.
- CNT_W, $clog2(MOD), width of the beat counter.
- FRAME_BLKS, 32, blocks per frame; legal range >= 1.
- BLK_W, $clog2(FRAME_BLKS), width of the block index.
- FLUSH_CYC, 4, idle cycles after the last alert before frame_done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle request to begin a frame.
- din_valid  in  1  input beat accepted this cycle.
- alert_mod10  out  1  one-cycle pulse per completed block; registered.
- cnt_val  out  CNT_W  current beat count within the block.
- blk_idx  out  BLK_W  current block index within the frame.
- busy  out  1  high in RUN and FLUSH.
- frame_done  out  1  one-cycle pulse at the end of FLUSH.
- seq_err  out  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. All state and outputs update on the rising edge of clk.
- Reset state: FSM = IDLE. cnt_val = 0, blk_idx = 0, alert_mod10 = 0, busy = 0, frame_done = 0, seq_err = 0.
- Reset mid-operation: rst asserted in any state returns the block to the reset state on the next edge. Any pending alert or frame_done is dropped.
- FSM states: IDLE, RUN, FLUSH. busy = (state != IDLE), registered with the state.
- IDLE:
  - din_valid is ignored; it is not an error.
  - frame_start=1 -> RUN on the next edge, with cnt_val = 0 and blk_idx = 0.
- RUN, din_valid=1 and cnt_val < MOD-1: cnt_val increments by 1.
- RUN, din_valid=1 and cnt_val == MOD-1 (block wrap):
  - cnt_val -> 0.
  - alert_mod10 = 1 in the following cycle only.
  - If blk_idx < FRAME_BLKS-1: blk_idx increments.
  - If blk_idx == FRAME_BLKS-1: blk_idx -> 0, state -> FLUSH, flush counter loads 0.
- RUN, din_valid=0: all state holds. Gaps of any length are legal.
- Alert latency: the pulse appears exactly 1 cycle after the clock edge that samples the MOD-th valid beat. Never more than one pulse per MOD accepted beats.
- FLUSH:
  - The flush counter increments every cycle.
  - When it reaches FLUSH_CYC-1: state -> IDLE and frame_done = 1 for the next cycle.
  - Total FLUSH duration is exactly FLUSH_CYC cycles, so the downstream FSM completes its window before frame_done.
- Errors (seq_err set, sticky):
  - frame_start=1 in RUN or FLUSH. The request is otherwise ignored; there is no restart.
  - din_valid=1 in FLUSH. The beat is dropped.
- Simultaneous events: frame_start and din_valid both high in IDLE -> enter RUN; that beat is not counted (counting begins the next cycle).
- Arithmetic: counters are unsigned. Wrap is explicit compare-to-limit, never natural overflow, so non-power-of-2 MOD and FRAME_BLKS work.
- Outputs cnt_val and blk_idx are the register values, with no combinational path from inputs.

Decomposition:
- Shared FFT control package (fft_ctrl_pkg):
  - State enum typedef (IDLE/RUN/FLUSH), 2 bits.
  - Constants MOD10_DEFAULT = 10 and DOWNSTREAM_CNT_CYC = 4; FLUSH_CYC defaults from the latter.
- Sub-module: mod_n_counter (parameter N; inputs clr, inc; outputs count, wrap). Instantiated twice: beat counter (N = MOD) and block counter (N = FRAME_BLKS).
- FSM, flush counter and error logic stay in the top module.

Test Plan:
- Reset check: rst held 3 cycles -> all outputs 0. With no frame_start, 20 cycles of din_valid=1 -> cnt_val stays 0, no alert, seq_err=0.
- Basic frame, FRAME_BLKS=2, MOD=10: frame_start, then 20 consecutive valid beats.
  - alert_mod10 pulses 1 cycle after the 10th beat and after the 20th beat; blk_idx 0 -> 1 -> 0.
  - busy drops and frame_done pulses exactly 4 cycles after the 20th-beat edge + 1.
- Gapped input: valid pattern 1,0,0,1 repeated -> alert only after the 10th accepted beat; cnt_val holds during gaps.
- Protocol errors:
  - frame_start during RUN at cnt_val=5 -> seq_err=1; counting continues undisturbed (cnt_val 6 on the next valid beat).
  - din_valid during FLUSH -> seq_err=1 and the beat is not counted.
- Reset mid-frame: rst at blk_idx=1, cnt_val=7 -> next cycle all outputs 0 and state IDLE. A subsequent frame_start runs a clean frame, with the first alert after 10 beats.
- Parameter sweep: MOD=4, FRAME_BLKS=3, continuous valid -> alerts exactly every 4 cycles (3 total), then frame_done 4 cycles after the last wrap.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared FFT control definitions: sequencer state encoding, default cycle
// counts and a width helper for modulo counters.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_state_e;

    localparam int MOD10_DEFAULT      = 10;
    localparam int DOWNSTREAM_CNT_CYC = 4;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_mod10_alert_if.sv
// Control/status bundle between the block sequencer and its frame controller.
interface cnt_mod10_alert_if #(
    parameter int CNT_W = 4,
    parameter int BLK_W = 5
);
    logic             frame_start;
    logic             din_valid;
    logic             alert_mod10;
    logic [CNT_W-1:0] cnt_val;
    logic [BLK_W-1:0] blk_idx;
    logic             busy;
    logic             frame_done;
    logic             seq_err;

    modport master (
        output frame_start, din_valid,
        input  alert_mod10, cnt_val, blk_idx, busy, frame_done, seq_err
    );

    modport slave (
        input  frame_start, din_valid,
        output alert_mod10, cnt_val, blk_idx, busy, frame_done, seq_err
    );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with explicit compare-to-limit wrap; wrap flags the
// increment that returns the count to zero.
module mod_n_counter
    import fft_ctrl_pkg::*;
#(
    parameter int N = MOD10_DEFAULT,
    parameter int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);
    logic [W-1:0] count_reg;

    assign wrap  = inc && (count_reg == W'(N - 1));
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= wrap ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/cnt_mod10_alert.sv
// Block sequencer: counts accepted beats per block, pulses alert_mod10 on each
// block wrap, and flushes the downstream window before signalling frame_done.
module cnt_mod10_alert
    import fft_ctrl_pkg::*;
#(
    parameter int MOD        = MOD10_DEFAULT,
    parameter int FRAME_BLKS = 32,
    parameter int FLUSH_CYC  = DOWNSTREAM_CNT_CYC,
    parameter int CNT_W      = clog2_min1(MOD),
    parameter int BLK_W      = clog2_min1(FRAME_BLKS)
) (
    input logic              clk,
    input logic              rst,
    cnt_mod10_alert_if.slave bus
);
    localparam int FLUSH_W = clog2_min1(FLUSH_CYC);

    fsm_state_e       state_reg;
    logic [FLUSH_W-1:0] flush_reg;
    logic             alert_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic             cnt_clr;
    logic             beat_inc;
    logic             beat_wrap;
    logic             blk_wrap;
    logic [CNT_W-1:0] cnt_val;
    logic [BLK_W-1:0] blk_idx;

    // Counters are held at zero while idle, so each frame starts clean and
    // beats arriving alongside frame_start are not counted.
    assign cnt_clr  = (state_reg == ST_IDLE);
    assign beat_inc = (state_reg == ST_RUN) && bus.din_valid;

    mod_n_counter #(.N(MOD), .W(CNT_W)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (beat_inc),
        .count (cnt_val),
        .wrap  (beat_wrap)
    );

    mod_n_counter #(.N(FRAME_BLKS), .W(BLK_W)) u_blk_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (beat_wrap),
        .count (blk_idx),
        .wrap  (blk_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            flush_reg <= '0;
            alert_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            alert_reg <= beat_wrap;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.frame_start) err_reg <= 1'b1;
                    if (blk_wrap) begin
                        state_reg <= ST_FLUSH;
                        flush_reg <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (bus.frame_start || bus.din_valid) err_reg <= 1'b1;
                    if (flush_reg == FLUSH_W'(FLUSH_CYC - 1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        flush_reg <= flush_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alert_mod10 = alert_reg;
    assign bus.cnt_val     = cnt_val;
    assign bus.blk_idx     = blk_idx;
    assign bus.busy        = busy_reg;
    assign bus.frame_done  = done_reg;
    assign bus.seq_err     = err_reg;
endmodule
